// File: rtl/ppg_pkg.sv
// Shared constants and helpers for the PPG sample path.
// Default sample width/depth and the pointer sizing function live here.
package ppg_pkg;

    localparam int PPG_SAMPLE_WIDTH = 10;
    localparam int PPG_FIFO_DEPTH   = 4;

    // Encoded as {read_accepted, write_accepted} so it can be built by a cast.
    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_PUSH = 2'b01,
        FIFO_POP  = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    function automatic int ptr_width(input int depth);
        int w;
        w = 1;
        while ((1 << w) < depth) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/ppg_fifo_mem.sv
// Sample storage: one synchronous write port, one synchronous read port.
// The read register doubles as the FIFO output and is the only reset state here.
module ppg_fifo_mem
    import ppg_pkg::*;
#(
    parameter int WIDTH = PPG_SAMPLE_WIDTH,
    parameter int DEPTH = PPG_FIFO_DEPTH,
    parameter int AW    = ptr_width(PPG_FIFO_DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem_reg [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= wr_data;
        end
    end

    // Read and write never target the same entry in one cycle: that would need
    // a non-empty FIFO with equal pointers, i.e. full, which blocks the write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_reg[rd_addr];
        end
    end

endmodule

// File: rtl/ppg_interface.sv
// PPG sample FIFO between the sensor front end and BPM processing.
// Owns pointers, occupancy and status flags; storage is in ppg_fifo_mem.
module ppg_interface
    import ppg_pkg::*;
#(
    parameter int WIDTH = PPG_SAMPLE_WIDTH,
    parameter int DEPTH = PPG_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic [WIDTH-1:0] Data_in,
    output logic [WIDTH-1:0] Data_out,
    output logic             full,
    output logic             empty
);

    localparam int AW = ptr_width(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          wr_accept;
    logic          rd_accept;
    fifo_op_e      op;

    // Flags come only from the registered count, never from the strobes.
    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);

    always_comb begin
        wr_accept   = wr_en && !full;
        rd_accept   = rd_en && !empty;
        op          = fifo_op_e'({rd_accept, wr_accept});
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        // DEPTH is a power of two, so natural pointer overflow is the wrap.
        if (wr_accept) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (rd_accept) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        case (op)
            FIFO_PUSH: count_next = count_reg + CW'(1);
            FIFO_POP:  count_next = count_reg - CW'(1);
            default:   count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    ppg_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_accept),
        .wr_addr (wr_ptr_reg),
        .wr_data (Data_in),
        .rd_en   (rd_accept),
        .rd_addr (rd_ptr_reg),
        .rd_data (Data_out)
    );

endmodule

// File: tb/tb_ppg_interface.sv
// Scoreboard bench for ppg_interface: stimulus queues hand-computed post-edge
// expectations, a monitor pops and compares one transaction per clock edge.
module tb_ppg_interface;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic       rd_en;
    logic [9:0] Data_in;
    logic [9:0] Data_out;
    logic       full;
    logic       empty;

    typedef struct packed {
        logic [9:0] d;
        logic       f;
        logic       e;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   txn    = 0;

    ppg_interface #(.WIDTH(10), .DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .Data_in  (Data_in),
        .Data_out (Data_out),
        .full     (full),
        .empty    (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Drive one cycle of strobes at the falling edge and queue the state
    // expected after the following rising edge.
    task automatic step(input logic w, input logic r, input logic [9:0] din,
                        input logic [9:0] ed, input logic ef, input logic ee);
        exp_t x;
        @(negedge clk);
        wr_en   = w;
        rd_en   = r;
        Data_in = din;
        x.d = ed;
        x.f = ef;
        x.e = ee;
        exp_q.push_back(x);
    endtask

    // Monitor: the DUT presents new state on every rising edge.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                txn++;
                $display("txn %0d: Data_out=%0d full=%0b empty=%0b (exp %0d %0b %0b)",
                         txn, Data_out, full, empty, x.d, x.f, x.e);
                chk("data_out", 32'(Data_out), 32'(x.d));
                chk("full", 32'(full), 32'(x.f));
                chk("empty", 32'(empty), 32'(x.e));
            end
        end
    end

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        Data_in = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_data_out", 32'(Data_out), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);

        // Overfill: fifth write dropped, reads return 1..4
        step(1, 0, 10'd1, 10'd0, 0, 0);
        step(1, 0, 10'd2, 10'd0, 0, 0);
        step(1, 0, 10'd3, 10'd0, 0, 0);
        step(1, 0, 10'd4, 10'd0, 1, 0);
        step(1, 0, 10'd5, 10'd0, 1, 0);
        step(0, 1, 10'd0, 10'd1, 0, 0);
        step(0, 1, 10'd0, 10'd2, 0, 0);
        step(0, 1, 10'd0, 10'd3, 0, 0);
        step(0, 1, 10'd0, 10'd4, 0, 1);

        // Wrap
        step(1, 0, 10'd10, 10'd4, 0, 0);
        step(1, 0, 10'd20, 10'd4, 0, 0);
        step(1, 0, 10'd30, 10'd4, 0, 0);
        step(1, 0, 10'd40, 10'd4, 1, 0);
        step(0, 1, 10'd0, 10'd10, 0, 0);
        step(0, 1, 10'd0, 10'd20, 0, 0);
        step(1, 0, 10'd50, 10'd20, 0, 0);
        step(1, 0, 10'd60, 10'd20, 1, 0);
        step(0, 1, 10'd0, 10'd30, 0, 0);
        step(0, 1, 10'd0, 10'd40, 0, 0);
        step(0, 1, 10'd0, 10'd50, 0, 0);
        step(0, 1, 10'd0, 10'd60, 0, 1);

        // Underflow: Data_out holds, stays empty
        for (int i = 0; i < 3; i++) step(0, 1, 10'd0, 10'd60, 0, 1);

        // Simultaneous with 2 entries, then full+both, then empty+both
        step(1, 0, 10'd7, 10'd60, 0, 0);
        step(1, 0, 10'd8, 10'd60, 0, 0);
        step(1, 1, 10'd9, 10'd7, 0, 0);
        step(1, 0, 10'd10, 10'd7, 0, 0);
        step(1, 0, 10'd11, 10'd7, 1, 0);
        step(1, 1, 10'd12, 10'd8, 0, 0);
        step(0, 1, 10'd0, 10'd9, 0, 0);
        step(0, 1, 10'd0, 10'd10, 0, 0);
        step(0, 1, 10'd0, 10'd11, 0, 1);
        step(1, 1, 10'd13, 10'd11, 0, 0);

        // Streaming: primed with 13, output lags input by one entry
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 10'(100 + i), (i == 0) ? 10'd13 : 10'(99 + i), 0, 0);
        end
        step(0, 1, 10'd0, 10'd119, 0, 1);

        // Load two samples, then reset asynchronously mid-cycle
        step(1, 0, 10'd200, 10'd119, 0, 0);
        step(1, 0, 10'd201, 10'd119, 0, 0);
        step(0, 0, 10'd0, 10'd119, 0, 0);
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_data_out", 32'(Data_out), 32'd0);
        chk("async_rst_full", 32'(full), 32'd0);
        chk("async_rst_empty", 32'(empty), 32'd1);
        wr_en   = 1'b1;
        Data_in = 10'd300;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_write_ignored", 32'(empty), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        wr_en = 1'b0;
        // Stored samples discarded: a read finds nothing
        step(0, 1, 10'd0, 10'd0, 0, 1);
        step(0, 0, 10'd0, 10'd0, 0, 1);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        #2;
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
